bus_mux_arb: RTL and testbench

Parametrised, registered N-channel bus multiplexer with per-channel valid/ready handshake and two selection modes: explicit select, which keeps the plain 8:1 mux behaviour, and round-robin arbitration among requesting channels. It sits between several bus sources and one bus sink. It replaces purely combinational select muxes wherever the sink can stall or several sources contend. The output is a single registered stage, so the sink sees registered data, valid and channel ID.

---
 rtl/bus_mux_arb_pkg.sv | 20 ++
 rtl/bus_mux_arb_if.sv | 30 +++
 rtl/bus_mux_arb_rr_pick.sv | 34 +++
 rtl/bus_mux_arb.sv | 94 +++++++++
 tb/tb_bus_mux_arb.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_mux_arb_pkg.sv
// Shared definitions for the registered bus multiplexer/arbiter:
// mode encodings, output-stage state and a width helper.
package bus_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

endpackage

// File: rtl/bus_mux_arb_if.sv
// Channel-side and sink-side handshake bundle of bus_mux_arb.
interface bus_mux_arb_if #(
   parameter int NCH = 8,
   parameter int W   = 8
);
   import bus_pkg::*;

   localparam int SELW = clog2(NCH);

   logic [NCH*W-1:0] in_data;
   logic [NCH-1:0]   in_valid;
   logic [NCH-1:0]   in_ready;
   logic             mode;
   logic [SELW-1:0]  sel;
   logic [W-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;
   logic [SELW-1:0]  out_ch;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );

endinterface

// File: rtl/bus_mux_arb_rr_pick.sv
// Rotating-priority search: first set request after ptr, wrapping modulo NCH.
module rr_pick
   import bus_pkg::*;
#(
   parameter  int NCH  = 8,
   localparam int SELW = clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_any
);

   logic [SELW:0]   sum;
   logic [SELW-1:0] idx;

   // Walk from the farthest offset to the nearest so the nearest hit wins.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = NCH; k >= 1; k--) begin
         sum = {1'b0, ptr} + (SELW+1)'(k);
         if (sum >= (SELW+1)'(NCH)) sum = sum - (SELW+1)'(NCH);
         idx = sum[SELW-1:0];
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_mux_arb.sv
// Registered N-channel bus mux with explicit-select and round-robin modes
// feeding a single-entry output stage.
module bus_mux_arb
   import bus_pkg::*;
#(
   parameter int NCH = 8,
   parameter int W   = 8
) (
   input logic          clk,
   input logic          rst,
   bus_mux_arb_if.slave bus
);

   localparam int SELW = clog2(NCH);

   state_t          state_q, state_d;
   logic [W-1:0]    data_q, data_d;
   logic [SELW-1:0] ch_q, ch_d;
   logic [SELW-1:0] ptr_q, ptr_d;

   logic [SELW-1:0] rr_idx;
   logic            rr_any;
   logic            sel_any;
   logic            cand_any;
   logic [SELW-1:0] cand_idx;
   logic [W-1:0]    cand_data;
   logic            ld;
   logic [NCH-1:0]  ready_vec;

   rr_pick #(.NCH(NCH)) u_pick (
      .req     (bus.in_valid),
      .ptr     (ptr_q),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   // A select value beyond NCH-1 simply never matches a channel.
   always_comb begin
      sel_any   = 1'b0;
      cand_data = '0;
      ready_vec = '0;
      state_d   = state_q;
      data_d    = data_q;
      ch_d      = ch_q;
      ptr_d     = ptr_q;

      for (int i = 0; i < NCH; i++)
         if (bus.sel == SELW'(i) && bus.in_valid[i]) sel_any = 1'b1;

      cand_idx = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
      cand_any = (bus.mode == MODE_RR) ? rr_any : sel_any;

      for (int i = 0; i < NCH; i++)
         if (cand_idx == SELW'(i)) cand_data = bus.in_data[i*W +: W];

      ld = (state_q == EMPTY) || bus.out_ready;

      if (ld && cand_any && !rst)
         for (int i = 0; i < NCH; i++)
            if (cand_idx == SELW'(i)) ready_vec[i] = 1'b1;

      if (ld) begin
         if (cand_any) begin
            state_d = FULL;
            data_d  = cand_data;
            ch_d    = cand_idx;
            if (bus.mode == MODE_RR) ptr_d = cand_idx;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   // ptr resets to the last channel so the first round-robin search starts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= SELW'(NCH - 1);
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.in_ready  = ready_vec;
   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Scoreboard bench for bus_mux_arb: an 8x8 instance and a 5x16 instance.
module tb_bus_mux_arb;
   import bus_pkg::*;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  ch;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   exp_t q8[$];
   exp_t q5[$];

   logic [7:0]  data8 [8] = '{8'hA0, 8'hA1, 8'h3C, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
   logic [15:0] data5 [5] = '{16'hC000, 16'hC111, 16'hC222, 16'hC333, 16'hC444};

   bus_mux_arb_if #(.NCH(8), .W(8))  bus8 ();
   bus_mux_arb_if #(.NCH(5), .W(16)) bus5 ();

   bus_mux_arb #(.NCH(8), .W(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));
   bus_mux_arb #(.NCH(5), .W(16)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit which, input logic [7:0] valid, input logic m,
                                input logic [2:0] s, input logic ordy);
      if (!which) begin
         bus8.in_valid  = valid;
         bus8.mode      = m;
         bus8.sel       = s;
         bus8.out_ready = ordy;
      end else begin
         bus5.in_valid  = valid[4:0];
         bus5.mode      = m;
         bus5.sel       = s;
         bus5.out_ready = ordy;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push8(input int ch);
      exp_t e;
      e.data = {8'h00, data8[ch]};
      e.ch   = 3'(ch);
      q8.push_back(e);
   endtask

   task automatic push5(input int ch);
      exp_t e;
      e.data = data5[ch];
      e.ch   = 3'(ch);
      q5.push_back(e);
   endtask

   // Each accepted word (valid and ready before the edge) is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus8.out_valid && bus8.out_ready) begin
         if (q8.size() == 0) checkOutput("sb8_extra_word", 32'(q8.size()), 32'd1);
         else begin
            e = q8.pop_front();
            checkOutput("sb8_data", 32'(bus8.out_data), 32'(e.data));
            checkOutput("sb8_ch", 32'(bus8.out_ch), 32'(e.ch));
         end
      end
      if (!rst && bus5.out_valid && bus5.out_ready) begin
         if (q5.size() == 0) checkOutput("sb5_extra_word", 32'(q5.size()), 32'd1);
         else begin
            e = q5.pop_front();
            checkOutput("sb5_data", 32'(bus5.out_data), 32'(e.data));
            checkOutput("sb5_ch", 32'(bus5.out_ch), 32'(e.ch));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) bus8.in_data[i*8 +: 8] = data8[i];
      for (int i = 0; i < 5; i++) bus5.in_data[i*16 +: 16] = data5[i];
      applyStimulus(0, 8'hFF, MODE_RR, 3'd0, 1'b1);
      applyStimulus(1, 8'h1F, MODE_RR, 3'd0, 1'b1);

      // Reset state with every channel requesting.
      #9;
      checkOutput("rst8_out_valid", 32'(bus8.out_valid), 32'd0);
      checkOutput("rst8_out_data", 32'(bus8.out_data), 32'd0);
      checkOutput("rst8_out_ch", 32'(bus8.out_ch), 32'd0);
      checkOutput("rst8_in_ready", 32'(bus8.in_ready), 32'd0);
      checkOutput("rst5_out_valid", 32'(bus5.out_valid), 32'd0);
      checkOutput("rst5_in_ready", 32'(bus5.in_ready), 32'd0);
      applyStimulus(1, 8'h00, MODE_RR, 3'd0, 1'b1);
      #3 rst = 1'b0;

      // Round-robin over all channels, then over channels 4 and 7.
      for (int i = 0; i < 8; i++) push8(i);
      push8(0);
      step(9);
      applyStimulus(0, 8'h90, MODE_RR, 3'd0, 1'b1);
      push8(4); push8(7); push8(4); push8(7);
      step(4);

      // Explicit select: granted channel, then an idle selected channel.
      applyStimulus(0, 8'h20, MODE_SEL, 3'd5, 1'b1);
      push8(5);
      #1 checkOutput("sel5_in_ready", 32'(bus8.in_ready), 32'h20);
      step(1);
      checkOutput("sel5_out_data", 32'(bus8.out_data), 32'hA5);
      checkOutput("sel5_out_ch", 32'(bus8.out_ch), 32'd5);
      applyStimulus(0, 8'h20, MODE_SEL, 3'd3, 1'b1);
      #1 checkOutput("sel3_in_ready", 32'(bus8.in_ready), 32'd0);
      step(1);
      checkOutput("sel3_out_valid", 32'(bus8.out_valid), 32'd0);
      checkOutput("sel3_hold_data", 32'(bus8.out_data), 32'hA5);
      checkOutput("sel3_hold_ch", 32'(bus8.out_ch), 32'd5);

      // Backpressure on a held channel-2 word, then same-cycle reload.
      applyStimulus(0, 8'h04, MODE_SEL, 3'd2, 1'b1);
      push8(2);
      step(1);
      applyStimulus(0, 8'hFF, MODE_RR, 3'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1 checkOutput("stall_in_ready", 32'(bus8.in_ready), 32'd0);
         step(1);
         checkOutput("stall_out_valid", 32'(bus8.out_valid), 32'd1);
         checkOutput("stall_out_ch", 32'(bus8.out_ch), 32'd2);
         checkOutput("stall_out_data", 32'(bus8.out_data), 32'h3C);
      end
      applyStimulus(0, 8'h48, MODE_RR, 3'd0, 1'b1);
      push8(3);
      #1 checkOutput("reload_in_ready", 32'(bus8.in_ready), 32'h08);
      step(1);
      checkOutput("reload_out_ch", 32'(bus8.out_ch), 32'd3);
      applyStimulus(0, 8'h00, MODE_RR, 3'd0, 1'b1);
      step(1);
      checkOutput("drain_out_valid", 32'(bus8.out_valid), 32'd0);

      // Asynchronous reset while a word is held.
      applyStimulus(0, 8'hFF, MODE_RR, 3'd0, 1'b0);
      step(1);
      checkOutput("pre_rst_out_ch", 32'(bus8.out_ch), 32'd4);
      #1 rst = 1'b1;
      #1;
      checkOutput("arst_out_valid", 32'(bus8.out_valid), 32'd0);
      checkOutput("arst_out_data", 32'(bus8.out_data), 32'd0);
      checkOutput("arst_out_ch", 32'(bus8.out_ch), 32'd0);
      checkOutput("arst_in_ready", 32'(bus8.in_ready), 32'd0);
      applyStimulus(0, 8'hFF, MODE_RR, 3'd0, 1'b1);
      #3 rst = 1'b0;
      push8(0);
      step(1);
      checkOutput("post_rst_out_ch", 32'(bus8.out_ch), 32'd0);
      applyStimulus(0, 8'h00, MODE_RR, 3'd0, 1'b1);
      step(1);

      // Five channels: wrap 0..4,0, then an out-of-range select.
      applyStimulus(1, 8'h1F, MODE_RR, 3'd0, 1'b1);
      for (int i = 0; i < 5; i++) push5(i);
      push5(0);
      step(6);
      applyStimulus(1, 8'h1F, MODE_SEL, 3'd6, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput("sel6_in_ready", 32'(bus5.in_ready), 32'd0);
         step(1);
         checkOutput("sel6_out_valid", 32'(bus5.out_valid), 32'd0);
      end
      applyStimulus(1, 8'h1F, MODE_SEL, 3'd4, 1'b1);
      push5(4);
      #1 checkOutput("sel4_in_ready", 32'(bus5.in_ready), 32'h10);
      step(1);
      applyStimulus(1, 8'h00, MODE_SEL, 3'd4, 1'b1);
      step(2);

      checkOutput("sb8_leftover", 32'(q8.size()), 32'd0);
      checkOutput("sb5_leftover", 32'(q5.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
